// File: rtl/proyecto_v2_fir.sv
// 16-tap programmable FIR: coefficients are loaded one strobe at a time, and each
// accepted sample is filtered by a single time-shared MAC. Optional clamp: FIR_SATURATE_EN.
module proyecto_v2_fir (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] data_in,
  input  logic [11:0] coef_in,
  input  logic        pulsador_carga_coef_i,
  input  logic        send_i,
  input  logic        cambio_coef_i,
  output logic [15:0] dato_out,
  output logic        led_full
);

  localparam int N_TAPS = 16;
  localparam int DW     = 12;
  localparam int PW     = 24;
  localparam int AW     = 28;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_MAC
  } state_t;

  state_t state_q, state_d;

  // Strobe edge detection
  logic carga_q, send_q, cambio_q;
  logic carga_ev, send_ev, cambio_ev;

  assign carga_ev  = pulsador_carga_coef_i & ~carga_q;
  assign send_ev   = send_i & ~send_q;
  assign cambio_ev = cambio_coef_i & ~cambio_q;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carga_q  <= 1'b0;
      send_q   <= 1'b0;
      cambio_q <= 1'b0;
    end else begin
      carga_q  <= pulsador_carga_coef_i;
      send_q   <= send_i;
      cambio_q <= cambio_coef_i;
    end
  end

  // Datapath storage
  logic signed [DW-1:0] coef_q [N_TAPS];
  logic signed [DW-1:0] x_q    [N_TAPS];
  logic [3:0]           idx_q;
  logic [4:0]           tap_q;
  logic signed [AW-1:0] acc_q;

  // Control strobes from the FSM
  logic       coef_we;
  logic       shift_en;
  logic       mac_en;
  logic       out_en;
  logic       full_set;
  logic       full_clr;
  logic [3:0] wr_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    coef_we  = 1'b0;
    shift_en = 1'b0;
    mac_en   = 1'b0;
    out_en   = 1'b0;
    full_set = 1'b0;
    full_clr = 1'b0;

    if (carga_ev) begin
      // Restart wins over everything, including a MAC in flight.
      state_d  = S_LOAD;
      full_clr = 1'b1;
      coef_we  = cambio_ev;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (cambio_ev) begin
            coef_we = 1'b1;
            if (idx_q == 4'd15) begin
              full_set = 1'b1;
              state_d  = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (send_ev) begin
            shift_en = 1'b1;
            state_d  = S_MAC;
          end
        end
        S_MAC: begin
          if (tap_q == 5'd16) begin
            out_en  = 1'b1;
            state_d = S_RUN;
          end else begin
            mac_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_idx = carga_ev ? 4'd0 : idx_q;

  // NOTE: coefficients and taps are plain flops (not a RAM), so they take the
  // asynchronous reset like any other register and start at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        coef_q[k] <= '0;
        x_q[k]    <= '0;
      end
      idx_q <= '0;
    end else begin
      if (coef_we) coef_q[wr_idx] <= coef_in;
      if (carga_ev)     idx_q <= cambio_ev ? 4'd1 : 4'd0;
      else if (coef_we) idx_q <= idx_q + 4'd1;
      if (shift_en) begin
        for (int k = N_TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
        x_q[0] <= data_in;
      end
    end
  end

  // One tap per cycle through a single multiplier
  logic signed [DW-1:0] c_sel, x_sel;
  logic signed [PW-1:0] c_ext, x_ext, prod;

  assign c_sel = coef_q[tap_q[3:0]];
  assign x_sel = x_q[tap_q[3:0]];
  assign c_ext = {{(PW-DW){c_sel[DW-1]}}, c_sel};
  assign x_ext = {{(PW-DW){x_sel[DW-1]}}, x_sel};
  assign prod  = c_ext * x_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      tap_q <= '0;
    end else if (shift_en) begin
      acc_q <= '0;
      tap_q <= '0;
    end else if (mac_en) begin
      acc_q <= acc_q + {{(AW-PW){prod[PW-1]}}, prod};
      tap_q <= tap_q + 5'd1;
    end
  end

  // Output scaling: acc >>> 11 occupies acc bits [27:11]
  logic [15:0] out_d;

`ifdef FIR_SATURATE_EN
  logic [16:0] res;
  assign res = acc_q[AW-1:11];
  always_comb begin
    out_d = res[15:0];
    if (res[16] != res[15]) out_d = res[16] ? 16'h8000 : 16'h7FFF;
  end
`else
  assign out_d = acc_q[26:11];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dato_out <= '0;
      led_full <= 1'b0;
    end else begin
      if (out_en)        dato_out <= out_d;
      if (full_clr)      led_full <= 1'b0;
      else if (full_set) led_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proyecto_v2_fir.sv
// Self-checking bench for proyecto_v2_fir: directed sequence with random data,
// checked against an arithmetic convolution model of the filter.
module tb_proyecto_v2_fir;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic [11:0] coef_in;
  logic        pulsador_carga_coef_i;
  logic        send_i;
  logic        cambio_coef_i;
  logic [15:0] dato_out;
  logic        led_full;

  proyecto_v2_fir dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in               (data_in),
    .coef_in               (coef_in),
    .pulsador_carga_coef_i (pulsador_carga_coef_i),
    .send_i                (send_i),
    .cambio_coef_i         (cambio_coef_i),
    .dato_out              (dato_out),
    .led_full              (led_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: coefficient set, sample history (newest first), last output
  int          mc [16];
  int          mx [16];
  int          set_buf [16];
  logic [15:0] last_exp;

  function automatic logic [15:0] model_out();
    longint s;
    s = 0;
    for (int k = 0; k < 16; k++) s += longint'(mc[k]) * longint'(mx[k]);
    s = s >>> 11;
`ifdef FIR_SATURATE_EN
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  task automatic model_shift(input int d);
    for (int k = 15; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      mc[k] = 0;
      mx[k] = 0;
    end
    last_exp = 16'h0000;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Loads set_buf[0..15]; optionally the first write rides on the restart strobe
  task automatic load_set(input bit restart, input string tag);
    for (int i = 0; i < 16; i++) begin
      coef_in       = set_buf[i][11:0];
      cambio_coef_i = 1'b1;
      if (restart && i == 0) pulsador_carga_coef_i = 1'b1;
      idle(1);
      cambio_coef_i         = 1'b0;
      pulsador_carga_coef_i = 1'b0;
      mc[i] = set_buf[i];
      idle(1);
      if (i == 14) check({tag, "_full_before_last"}, {15'b0, led_full}, 16'h0000);
      if (i == 15) check({tag, "_full_after_last"},  {15'b0, led_full}, 16'h0001);
    end
  endtask

  // One send; output must hold through 16 cycles and update on the 17th
  task automatic send(input int d, input string tag, input bit drop_extra);
    logic [15:0] exp;
    data_in = d[11:0];
    send_i  = 1'b1;
    idle(1);
    send_i = 1'b0;
    model_shift(d);
    exp = model_out();
    if (drop_extra) begin
      idle(4);
      data_in = 12'h5A5;
      send_i  = 1'b1;
      idle(1);
      send_i = 1'b0;
      idle(11);
    end else begin
      idle(16);
    end
    check({tag, "_hold"}, dato_out, last_exp);
    idle(1);
    check(tag, dato_out, exp);
    last_exp = exp;
  endtask

  int rnd;

  initial begin
    rst                   = 1'b1;
    data_in               = '0;
    coef_in               = '0;
    pulsador_carga_coef_i = 1'b0;
    send_i                = 1'b0;
    cambio_coef_i         = 1'b0;
    model_clear();

    idle(3);
    check("reset_dato_out", dato_out, 16'h0000);
    check("reset_led_full", {15'b0, led_full}, 16'h0000);
    rst = 1'b0;
    idle(2);

    // send before any coefficients exist is ignored
    data_in = 12'h7FF;
    send_i  = 1'b1;
    idle(1);
    send_i = 1'b0;
    idle(20);
    check("idle_send_ignored", dato_out, 16'h0000);

    // Spec coefficient set, first write together with the restart strobe
    set_buf = '{-99, 65, 136, 33, -156, -86, 376, 854,
                854, 376, -86, -156, 33, 136, 65, -99};
    load_set(1'b1, "load_spec");

    // Impulse response
    send(2047, "impulse_0", 1'b0);
    check("impulse_0_const", dato_out, 16'hFF9D);
    for (int i = 1; i < 16; i++) send(0, $sformatf("impulse_%0d", i), 1'b0);

    // DC response
    for (int i = 0; i < 16; i++) send(2047, $sformatf("dc_%0d", i), 1'b0);
    check("dc_final_const", dato_out, 16'd2244);

    // A second send during MAC is dropped
    send(-1000, "drop_during_mac", 1'b1);
    send(500, "after_drop", 1'b0);

    // Reload while in RUN: restart alone, led_full falls at once, sends ignored
    pulsador_carga_coef_i = 1'b1;
    idle(1);
    pulsador_carga_coef_i = 1'b0;
    check("reload_full_falls", {15'b0, led_full}, 16'h0000);
    data_in = 12'h4D2;
    send_i  = 1'b1;
    idle(1);
    send_i = 1'b0;
    idle(20);
    check("load_send_ignored", dato_out, last_exp);

    for (int i = 0; i < 16; i++) begin
      rnd = int'($urandom_range(0, 4095)) - 2048;
      set_buf[i] = rnd;
    end
    load_set(1'b0, "load_rand");
    for (int i = 0; i < 12; i++) begin
      rnd = int'($urandom_range(0, 4095)) - 2048;
      send(rnd, $sformatf("rand_%0d", i), 1'b0);
    end

    // Overflow corner: full-scale negative coefficients and samples
    for (int i = 0; i < 16; i++) set_buf[i] = -2048;
    load_set(1'b1, "load_ovf");
    for (int i = 0; i < 16; i++) send(-2048, $sformatf("ovf_%0d", i), 1'b0);
`ifdef FIR_SATURATE_EN
    check("ovf_final_const", dato_out, 16'h7FFF);
`else
    check("ovf_final_const", dato_out, 16'h8000);
`endif

    // Asynchronous reset in the middle of a MAC
    data_in = 12'h123;
    send_i  = 1'b1;
    idle(1);
    send_i = 1'b0;
    idle(5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dato_out", dato_out, 16'h0000);
    check("async_rst_led_full", {15'b0, led_full}, 16'h0000);
    model_clear();
    idle(2);
    #2 rst = 1'b0;
    idle(2);
    data_in = 12'h7FF;
    send_i  = 1'b1;
    idle(1);
    send_i = 1'b0;
    idle(20);
    check("post_rst_send_ignored", dato_out, 16'h0000);
    check("post_rst_led_full", {15'b0, led_full}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
